// File: rtl/iommu_pkg.sv
// Shared IOMMU types for the DDTC controller: extended device context
// and the controller state encoding.
package iommu_pkg;

  typedef struct packed {
    logic [63:0] tc;
    logic [63:0] iohgatp;
    logic [63:0] ta;
    logic [63:0] fsc;
  } dc_ext_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WREQ,
    WWAIT,
    INVAL
  } ddtc_ctrl_state_e;

endpackage

// File: rtl/iommu_rr_arbiter.sv
// Round-robin grant over N requesters. The pointer moves past the
// granted requester only when the grant is actually taken.
module iommu_rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] gnt
);

  logic [IW-1:0] ptr_q;
  int            gi;

  always_comb begin
    int j;
    logic found;
    gnt   = '0;
    gi    = 0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        gi     = j;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (gi == N - 1) ? '0 : IW'(gi + 1);
    end
  end

endmodule

// File: rtl/iommu_ddtc_ctrl.sv
// DDTC sequencer: round-robin DC requests, priority INVAL_DDT flushes,
// miss walk and refill. IOMMU_DDTC_CTRL_STATS_EN adds hit/miss/flush counters.
module iommu_ddtc_ctrl
  import iommu_pkg::*;
#(
  parameter int N_REQ           = 2,
  parameter int DEVICE_ID_WIDTH = 24,
  localparam int DW = DEVICE_ID_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_REQ-1:0]    req_valid_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  logic [N_REQ*DW-1:0] req_did_i,
  output logic [N_REQ-1:0]    resp_valid_o,
  output dc_ext_t             resp_dc_o,
  output logic                resp_fault_o,
  input  logic                inval_valid_i,
  output logic                inval_ready_o,
  input  logic                inval_dv_i,
  input  logic [DW-1:0]       inval_did_i,
  output logic                ddtc_lookup_o,
  output logic [DW-1:0]       ddtc_lu_did_o,
  input  logic                ddtc_lu_hit_i,
  input  dc_ext_t             ddtc_lu_content_i,
  output logic                ddtc_update_o,
  output logic [DW-1:0]       ddtc_up_did_o,
  output dc_ext_t             ddtc_up_content_o,
  output logic                ddtc_flush_o,
  output logic                ddtc_flush_dv_o,
  output logic [DW-1:0]       ddtc_flush_did_o,
  output logic                walk_valid_o,
  input  logic                walk_ready_i,
  output logic [DW-1:0]       walk_did_o,
  input  logic                walk_rvalid_i,
  input  dc_ext_t             walk_dc_i,
  input  logic                walk_fault_i
`ifdef IOMMU_DDTC_CTRL_STATS_EN
  ,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o,
  output logic [31:0]         flush_cnt_o
`endif
);

  ddtc_ctrl_state_e state_q, state_d;
  logic [DW-1:0]    did_q, inv_did_q, sel_did;
  logic [N_REQ-1:0] gnt_q, arb_req, gnt;
  logic             inv_dv_q, blk_q, inval_acc;

  // Once a flush has gone out, a waiting requester is served before the next one.
  assign inval_acc = (state_q == IDLE) && inval_valid_i
                   && !(blk_q && |req_valid_i);
  assign arb_req   = (state_q == IDLE && !inval_acc) ? req_valid_i : '0;

  iommu_rr_arbiter #(.N(N_REQ)) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (arb_req),
    .accept (|gnt),
    .gnt    (gnt)
  );

  always_comb begin
    sel_did = '0;
    for (int g = 0; g < N_REQ; g++) begin
      if (gnt[g]) sel_did = sel_did | req_did_i[g*DW +: DW];
    end
  end

  always_comb begin
    state_d           = state_q;
    req_ready_o       = '0;
    resp_valid_o      = '0;
    resp_dc_o         = '0;
    resp_fault_o      = 1'b0;
    inval_ready_o     = 1'b0;
    ddtc_lookup_o     = 1'b0;
    ddtc_lu_did_o     = '0;
    ddtc_update_o     = 1'b0;
    ddtc_up_did_o     = '0;
    ddtc_up_content_o = '0;
    ddtc_flush_o      = 1'b0;
    ddtc_flush_dv_o   = 1'b0;
    ddtc_flush_did_o  = '0;
    walk_valid_o      = 1'b0;
    walk_did_o        = '0;
    unique case (state_q)
      IDLE: begin
        inval_ready_o = inval_acc;
        if (inval_acc) begin
          state_d = INVAL;
        end else if (|gnt) begin
          req_ready_o = gnt;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        ddtc_lookup_o = 1'b1;
        ddtc_lu_did_o = did_q;
        if (ddtc_lu_hit_i) begin
          resp_valid_o = gnt_q;
          resp_dc_o    = ddtc_lu_content_i;
          state_d      = IDLE;
        end else begin
          state_d = WREQ;
        end
      end
      WREQ: begin
        walk_valid_o = 1'b1;
        walk_did_o   = did_q;
        if (walk_ready_i) state_d = WWAIT;
      end
      WWAIT: begin
        if (walk_rvalid_i) begin
          resp_valid_o = gnt_q;
          resp_fault_o = walk_fault_i;
          if (!walk_fault_i) begin
            resp_dc_o         = walk_dc_i;
            ddtc_update_o     = 1'b1;
            ddtc_up_did_o     = did_q;
            ddtc_up_content_o = walk_dc_i;
          end
          state_d = IDLE;
        end
      end
      INVAL: begin
        ddtc_flush_o     = 1'b1;
        ddtc_flush_dv_o  = inv_dv_q;
        ddtc_flush_did_o = inv_did_q;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      did_q     <= '0;
      gnt_q     <= '0;
      inv_dv_q  <= 1'b0;
      inv_did_q <= '0;
      blk_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (inval_acc) begin
        inv_dv_q  <= inval_dv_i;
        inv_did_q <= inval_did_i;
      end else if (|gnt) begin
        did_q <= sel_did;
        gnt_q <= gnt;
        blk_q <= 1'b0;
      end
      if (state_q == INVAL) blk_q <= 1'b1;
    end
  end

`ifdef IOMMU_DDTC_CTRL_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_o   <= '0;
      miss_cnt_o  <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (state_q == LOOKUP && ddtc_lu_hit_i && ~&hit_cnt_o)
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if (state_q == LOOKUP && !ddtc_lu_hit_i && ~&miss_cnt_o)
        miss_cnt_o <= miss_cnt_o + 32'd1;
      if (state_q == INVAL && ~&flush_cnt_o)
        flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iommu_ddtc_ctrl.sv
// Bench for iommu_ddtc_ctrl: DDTC/walker responders, a transaction-level
// predictor checked every cycle, and directed scenarios with literal checks.
module tb_iommu_ddtc_ctrl;
  import iommu_pkg::*;

  localparam int N  = 2;
  localparam int DW = 24;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [N*DW-1:0] req_did_i = '0;
  logic [N-1:0]    resp_valid_o;
  dc_ext_t         resp_dc_o;
  logic            resp_fault_o;
  logic            inval_valid_i = 1'b0;
  logic            inval_ready_o;
  logic            inval_dv_i = 1'b0;
  logic [DW-1:0]   inval_did_i = '0;
  logic            ddtc_lookup_o;
  logic [DW-1:0]   ddtc_lu_did_o;
  logic            ddtc_lu_hit_i = 1'b0;
  dc_ext_t         ddtc_lu_content_i = '0;
  logic            ddtc_update_o;
  logic [DW-1:0]   ddtc_up_did_o;
  dc_ext_t         ddtc_up_content_o;
  logic            ddtc_flush_o;
  logic            ddtc_flush_dv_o;
  logic [DW-1:0]   ddtc_flush_did_o;
  logic            walk_valid_o;
  logic            walk_ready_i = 1'b0;
  logic [DW-1:0]   walk_did_o;
  logic            walk_rvalid_i = 1'b0;
  dc_ext_t         walk_dc_i = '0;
  logic            walk_fault_i = 1'b0;
`ifdef IOMMU_DDTC_CTRL_STATS_EN
  logic [31:0]     hit_cnt, miss_cnt, flush_cnt;
`endif

  iommu_ddtc_ctrl #(.N_REQ(N), .DEVICE_ID_WIDTH(DW)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_did_i         (req_did_i),
    .resp_valid_o      (resp_valid_o),
    .resp_dc_o         (resp_dc_o),
    .resp_fault_o      (resp_fault_o),
    .inval_valid_i     (inval_valid_i),
    .inval_ready_o     (inval_ready_o),
    .inval_dv_i        (inval_dv_i),
    .inval_did_i       (inval_did_i),
    .ddtc_lookup_o     (ddtc_lookup_o),
    .ddtc_lu_did_o     (ddtc_lu_did_o),
    .ddtc_lu_hit_i     (ddtc_lu_hit_i),
    .ddtc_lu_content_i (ddtc_lu_content_i),
    .ddtc_update_o     (ddtc_update_o),
    .ddtc_up_did_o     (ddtc_up_did_o),
    .ddtc_up_content_o (ddtc_up_content_o),
    .ddtc_flush_o      (ddtc_flush_o),
    .ddtc_flush_dv_o   (ddtc_flush_dv_o),
    .ddtc_flush_did_o  (ddtc_flush_did_o),
    .walk_valid_o      (walk_valid_o),
    .walk_ready_i      (walk_ready_i),
    .walk_did_o        (walk_did_o),
    .walk_rvalid_i     (walk_rvalid_i),
    .walk_dc_i         (walk_dc_i),
    .walk_fault_i      (walk_fault_i)
`ifdef IOMMU_DDTC_CTRL_STATS_EN
    ,
    .hit_cnt_o         (hit_cnt),
    .miss_cnt_o        (miss_cnt),
    .flush_cnt_o       (flush_cnt)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic dc_ext_t mk_dc(input logic [31:0] tag);
    dc_ext_t d;
    d.tc      = 64'h1 | {24'h0, tag, 8'h0};
    d.iohgatp = {32'h0, tag};
    d.ta      = {tag, 32'h0000_dead};
    d.fsc     = ~{32'h0, tag};
    return d;
  endfunction

  // Environment: requesters, DDTC array and DDT walker
  int            rq_cnt[N];
  logic [DW-1:0] rq_did[N];
  int            inv_cnt = 0;
  logic          inv_dv = 1'b0;
  logic [DW-1:0] inv_did = '0;
  bit            cache_v[256];
  dc_ext_t       cache_dc[256];
  int            w_rdly = 0, w_rvdly = 1, wv_cnt = 0, rv_cnt = 0;
  bit            w_pend = 1'b0, w_fault = 1'b0;
  dc_ext_t       w_dc;

  always @(posedge clk_i) begin
    logic [N-1:0] acc_r;
    logic         acc_i, hs;
    acc_r = req_valid_i & req_ready_o;
    acc_i = inval_valid_i & inval_ready_o;
    hs    = walk_valid_o & walk_ready_i;
    #1;
    for (int g = 0; g < N; g++) begin
      if (acc_r[g] && rq_cnt[g] > 0) rq_cnt[g]--;
      req_valid_i[g] = rst_ni && rq_cnt[g] > 0;
      req_did_i[g*DW +: DW] = rq_did[g];
    end
    if (acc_i && inv_cnt > 0) inv_cnt--;
    inval_valid_i = rst_ni && inv_cnt > 0;
    inval_dv_i    = inv_dv;
    inval_did_i   = inv_did;
    ddtc_lu_hit_i = ddtc_lookup_o && cache_v[ddtc_lu_did_o[7:0]];
    ddtc_lu_content_i = ddtc_lu_hit_i ? cache_dc[ddtc_lu_did_o[7:0]] : '0;
    walk_ready_i  = 1'b0;
    walk_rvalid_i = 1'b0;
    walk_dc_i     = '0;
    walk_fault_i  = 1'b0;
    if (!rst_ni) begin
      w_pend = 1'b0;
      wv_cnt = 0;
    end else begin
      if (hs) begin
        w_pend = 1'b1;
        rv_cnt = w_rvdly - 1;
      end else if (w_pend) rv_cnt--;
      if (w_pend && rv_cnt <= 0) begin
        walk_rvalid_i = 1'b1;
        walk_fault_i  = w_fault;
        walk_dc_i     = w_fault ? '0 : w_dc;
        w_pend        = 1'b0;
      end
      if (walk_valid_o) begin
        if (wv_cnt >= w_rdly) begin
          walk_ready_i = 1'b1;
          wv_cnt       = 0;
        end else wv_cnt++;
      end else wv_cnt = 0;
    end
  end

  // Predictor: one outstanding job (flush, lookup or walk) at a time
  bit            m_flush = 0, m_lk = 0, m_wreq = 0, m_wwait = 0, m_blk = 0;
  int            m_ptr = 0, m_g = 0;
  logic [DW-1:0] m_did = '0, m_fdid = '0;
  bit            m_fdv = 0;
  int            glog[$];

  function automatic bit m_idle();
    return !(m_flush || m_lk || m_wreq || m_wwait);
  endfunction

  always @(negedge clk_i) begin
    logic [N-1:0]  e_rrdy, e_rv;
    dc_ext_t       e_dc, e_upc;
    logic          e_flt, e_irdy, e_lk, e_upd, e_fl, e_fdv, e_wv;
    logic [DW-1:0] e_ludid, e_updid, e_fdid, e_wdid;
    bit            grant, hit;
    int            gsel;
    e_rrdy = '0; e_rv = '0; e_dc = '0; e_upc = '0; e_flt = 0;
    e_irdy = 0; e_lk = 0; e_upd = 0; e_fl = 0; e_fdv = 0; e_wv = 0;
    e_ludid = '0; e_updid = '0; e_fdid = '0; e_wdid = '0;
    grant = 0; hit = 0; gsel = 0;
    if (rst_ni) begin
      if (m_flush) begin
        e_fl = 1; e_fdv = m_fdv; e_fdid = m_fdid;
      end else if (m_lk) begin
        e_lk = 1; e_ludid = m_did;
        hit = cache_v[m_did[7:0]];
        if (hit) begin
          e_rv[m_g] = 1'b1;
          e_dc = cache_dc[m_did[7:0]];
        end
      end else if (m_wreq) begin
        e_wv = 1; e_wdid = m_did;
      end else if (m_wwait) begin
        if (walk_rvalid_i) begin
          e_rv[m_g] = 1'b1;
          e_flt = walk_fault_i;
          if (!walk_fault_i) begin
            e_dc = walk_dc_i; e_upd = 1; e_updid = m_did; e_upc = walk_dc_i;
          end
        end
      end else begin
        e_irdy = inval_valid_i && !(m_blk && |req_valid_i);
        if (!e_irdy) begin
          for (int k = 0; k < N; k++) begin
            if (!grant && req_valid_i[(m_ptr + k) % N]) begin
              grant = 1; gsel = (m_ptr + k) % N;
            end
          end
          if (grant) e_rrdy[gsel] = 1'b1;
        end
      end
    end
    chk("req_ready", 256'(req_ready_o), 256'(e_rrdy));
    chk("resp_valid", 256'(resp_valid_o), 256'(e_rv));
    chk("resp_dc", resp_dc_o, e_dc);
    chk("resp_fault", 256'(resp_fault_o), 256'(e_flt));
    chk("inval_ready", 256'(inval_ready_o), 256'(e_irdy));
    chk("lookup", 256'(ddtc_lookup_o), 256'(e_lk));
    chk("lu_did", 256'(ddtc_lu_did_o), 256'(e_ludid));
    chk("update", 256'(ddtc_update_o), 256'(e_upd));
    chk("up_did", 256'(ddtc_up_did_o), 256'(e_updid));
    chk("up_content", ddtc_up_content_o, e_upc);
    chk("flush", 256'(ddtc_flush_o), 256'(e_fl));
    chk("flush_dv", 256'(ddtc_flush_dv_o), 256'(e_fdv));
    chk("flush_did", 256'(ddtc_flush_did_o), 256'(e_fdid));
    chk("walk_valid", 256'(walk_valid_o), 256'(e_wv));
    chk("walk_did", 256'(walk_did_o), 256'(e_wdid));
    if (!rst_ni) begin
      m_flush = 0; m_lk = 0; m_wreq = 0; m_wwait = 0; m_blk = 0; m_ptr = 0;
    end else begin
      for (int g = 0; g < N; g++) if (req_ready_o[g]) glog.push_back(g);
      if (ddtc_flush_o) begin
        glog.push_back(-1);
        for (int i = 0; i < 256; i++)
          if (!ddtc_flush_dv_o || i == int'(ddtc_flush_did_o)) cache_v[i] = 0;
      end
      if (ddtc_update_o && ddtc_up_content_o.tc[0]) begin
        cache_v[ddtc_up_did_o[7:0]]  = 1;
        cache_dc[ddtc_up_did_o[7:0]] = ddtc_up_content_o;
      end
      if (m_flush) begin
        m_flush = 0; m_blk = 1;
      end else if (m_lk) begin
        m_lk = 0; m_wreq = !hit;
      end else if (m_wreq) begin
        if (walk_ready_i) begin m_wreq = 0; m_wwait = 1; end
      end else if (m_wwait) begin
        if (walk_rvalid_i) m_wwait = 0;
      end else if (e_irdy) begin
        m_flush = 1; m_fdv = inval_dv_i; m_fdid = inval_did_i;
      end else if (grant) begin
        m_lk = 1; m_g = gsel; m_did = req_did_i[gsel*DW +: DW];
        m_ptr = (gsel + 1) % N; m_blk = 0;
      end
    end
  end

  task automatic settle(input string nm, input int budget);
    int k, pend;
    k = 0;
    forever begin
      pend = inv_cnt;
      for (int g = 0; g < N; g++) pend += rq_cnt[g];
      if (pend == 0 && m_idle() && !w_pend) break;
      @(negedge clk_i); #1;
      k++;
      if (k > budget) begin
        n_checks++; n_errs++;
        $display("FAIL %s: timeout after %0d cycles", nm, budget);
        break;
      end
    end
  endtask

  dc_ext_t dc_a, dc_b, dc_c, dc_d;

  initial begin
    int k, ku, kf, early;
    dc_a = mk_dc(32'hA1); dc_b = mk_dc(32'hB2);
    dc_c = mk_dc(32'hC3); dc_d = mk_dc(32'hD4);
    for (int g = 0; g < N; g++) begin rq_cnt[g] = 0; rq_did[g] = '0; end
    for (int i = 0; i < 256; i++) begin cache_v[i] = 0; cache_dc[i] = '0; end
    w_dc = '0;
    @(negedge clk_i);
    chk("rst_ready", 256'(req_ready_o), 256'(0));
    chk("rst_walk", 256'(walk_valid_o), 256'(0));
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b1;

    // 1: hit on requester 0
    @(negedge clk_i); #1;
    cache_v[8'h12] = 1; cache_dc[8'h12] = dc_a;
    rq_did[0] = 24'h12; rq_cnt[0] = 1;
    @(negedge clk_i);
    chk("t1_ready", 256'(req_ready_o), 256'(2'b01));
    @(negedge clk_i);
    chk("t1_resp", 256'(resp_valid_o), 256'(2'b01));
    chk("t1_dc", resp_dc_o, dc_a);
    chk("t1_nowalk", 256'(walk_valid_o), 256'(0));
    #1 settle("t1_idle", 20);

    // 2: miss, walker ready after 2 cycles, data 3 cycles later
    w_rdly = 2; w_rvdly = 3; w_dc = dc_b; w_fault = 0;
    rq_did[0] = 24'h34; rq_cnt[0] = 1;
    k = 0;
    do begin @(negedge clk_i); k++; end while (!ddtc_update_o && k < 30);
    chk("t2_lat", 256'(k), 256'(8));
    chk("t2_updid", 256'(ddtc_up_did_o), 256'(24'h34));
    chk("t2_resp", 256'(resp_valid_o), 256'(2'b01));
    chk("t2_dc", resp_dc_o, dc_b);
    #1 settle("t2_idle", 20);

    // 3: walk fault on requester 1
    w_rdly = 0; w_rvdly = 1; w_fault = 1;
    rq_did[1] = 24'h56; rq_cnt[1] = 1;
    k = 0;
    do begin @(negedge clk_i); k++; end while (resp_valid_o == '0 && k < 30);
    chk("t3_resp", 256'(resp_valid_o), 256'(2'b10));
    chk("t3_fault", 256'(resp_fault_o), 256'(1));
    chk("t3_noupd", 256'(ddtc_update_o), 256'(0));
    w_fault = 0;
    #1 settle("t3_idle", 20);

    // 4: back-to-back invals interleave with requesters
    cache_v[8'h20] = 1; cache_dc[8'h20] = dc_c;
    glog.delete();
    inv_dv = 1; inv_did = 24'h12; inv_cnt = 2;
    rq_did[0] = 24'h20; rq_did[1] = 24'h34; rq_cnt[0] = 1; rq_cnt[1] = 1;
    k = 0;
    do begin @(negedge clk_i); k++; end while (!ddtc_flush_o && k < 10);
    chk("t4_fdid", 256'(ddtc_flush_did_o), 256'(24'h12));
    #1 settle("t4_idle", 40);
    chk("t4_seq_len", 256'(glog.size()), 256'(4));
    for (int i = 0; i < 4; i++)
      chk("t4_seq", 256'(i < glog.size() ? glog[i] : 99),
          256'((i % 2 == 0) ? -1 : i / 2));

    // 5: inval held off during the walk, flush after the update
    w_rdly = 0; w_rvdly = 4; w_dc = dc_d;
    rq_did[1] = 24'h60; rq_cnt[1] = 1;
    k = 0;
    do begin @(negedge clk_i); k++; end
      while (!(walk_valid_o && walk_ready_i) && k < 20);
    inv_dv = 0; inv_did = '0; inv_cnt = 1;
    k = 0; ku = -1; kf = -1; early = 0;
    while (kf < 0 && k < 20) begin
      @(negedge clk_i); k++;
      if (inval_ready_o && ku < 0) early++;
      if (ddtc_update_o) ku = k;
      if (ddtc_flush_o) kf = k;
    end
    chk("t5_early", 256'(early), 256'(0));
    chk("t5_upd", 256'(ku), 256'(4));
    chk("t5_gap", 256'(kf - ku), 256'(2));
    #1 settle("t5_idle", 20);

    // 6: continuous hits alternate, then reset during WREQ
    cache_v[8'h70] = 1; cache_dc[8'h70] = dc_a;
    cache_v[8'h71] = 1; cache_dc[8'h71] = dc_c;
    glog.delete();
    rq_did[0] = 24'h70; rq_did[1] = 24'h71; rq_cnt[0] = 4; rq_cnt[1] = 4;
    settle("t6_idle", 60);
    for (int i = 0; i < 4; i++)
      chk("t6_grant", 256'(i < glog.size() ? glog[i] : 99), 256'(i % 2));
    w_rdly = 20;
    rq_did[0] = 24'h99; rq_cnt[0] = 1;
    k = 0;
    do begin @(negedge clk_i); k++; end while (!walk_valid_o && k < 10);
    chk("t6_inwreq", 256'(walk_valid_o), 256'(1));
    #2 rst_ni = 1'b0;
    @(negedge clk_i);
    chk("t6_rst_walk", 256'(walk_valid_o), 256'(0));
    chk("t6_rst_did", 256'(walk_did_o), 256'(0));
    chk("t6_rst_lu", 256'(ddtc_lookup_o), 256'(0));
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    w_rdly = 0;
    @(negedge clk_i); #1;
    glog.delete();
    rq_did[1] = 24'h70; rq_cnt[1] = 1;
    settle("t6_recover", 20);
    chk("t6_after", 256'(glog.size() > 0 ? glog[0] : 99), 256'(1));
`ifdef IOMMU_DDTC_CTRL_STATS_EN
    chk("stat_hit", 256'(hit_cnt != 0), 256'(1));
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
